// File: rtl/hazard_flush_ctrl_pkg.sv
// hazard_flush_ctrl_pkg: shared FSM encodings and constants for the hazard controller
package hazard_flush_ctrl_pkg;
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;
    localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/hazard_flush_ctrl_sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] q
);
    always_ff @(posedge clk) begin
        if (reset) q <= '0;
        else if (inc && q != '1) q <= q + 1'b1;
    end
endmodule

// File: rtl/hazard_flush_ctrl.sv
// hazard_flush_ctrl: load-use stall and redirect flush control for the 5-stage pipeline
module hazard_flush_ctrl
    import hazard_flush_ctrl_pkg::*;
#(
    parameter int STALL_CYCLES = 1,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             EX_MemRead,
    input  logic [4:0]       EX_rt,
    input  logic [4:0]       ID_rs,
    input  logic [4:0]       ID_rt,
    input  logic             ID_UsesRt,
    input  logic             EX_BranchTaken,
    input  logic             ID_Jump,
    output logic             PCWrite,
    output logic             IFID_Write,
    output logic             IF_Flush,
    output logic             ID_Flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    state_t     state, state_n;
    logic [3:0] cnt, cnt_n;
    logic       lu, br_flush;

    assign lu = EX_MemRead && EX_rt != REG_ZERO &&
                (EX_rt == ID_rs || (ID_UsesRt && EX_rt == ID_rt));

    always_ff @(posedge clk) begin
        state <= state_n;
        cnt   <= cnt_n;
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        PCWrite    = 1'b1;
        IFID_Write = 1'b1;
        IF_Flush   = 1'b0;
        ID_Flush   = 1'b0;
        br_flush   = 1'b0;
        if (reset) begin
            PCWrite    = 1'b0;
            IFID_Write = 1'b0;
            IF_Flush   = 1'b1;
            ID_Flush   = 1'b1;
            state_n    = RUN;
            cnt_n      = 4'd0;
        end else if (state == FLUSH) begin
            // wrong-path hazards are ignored while bubbles drain
            IF_Flush = 1'b1;
            ID_Flush = 1'b1;
            br_flush = 1'b1;
            cnt_n    = cnt - 4'd1;
            state_n  = cnt <= 4'd1 ? RUN : FLUSH;
        end else if (EX_BranchTaken) begin
            IF_Flush = 1'b1;
            ID_Flush = 1'b1;
            br_flush = 1'b1;
            state_n  = FLUSH_CYCLES > 1 ? FLUSH : RUN;
            cnt_n    = FLUSH_CYCLES > 1 ? 4'(FLUSH_CYCLES - 1) : 4'd0;
        end else if (state == RUN && ID_Jump) begin
            IF_Flush = 1'b1;
        end else if (state == STALL) begin
            PCWrite    = 1'b0;
            IFID_Write = 1'b0;
            ID_Flush   = 1'b1;
            cnt_n      = cnt - 4'd1;
            state_n    = cnt <= 4'd1 ? RUN : STALL;
        end else if (lu) begin
            PCWrite    = 1'b0;
            IFID_Write = 1'b0;
            ID_Flush   = 1'b1;
            state_n    = STALL_CYCLES > 1 ? STALL : RUN;
            cnt_n      = STALL_CYCLES > 1 ? 4'(STALL_CYCLES - 1) : 4'd0;
        end else begin
            state_n = RUN;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk(clk), .reset(reset), .inc(!PCWrite), .q(stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk(clk), .reset(reset), .inc(br_flush), .q(flush_cnt)
    );
endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// tb_hazard_flush_ctrl: directed checks on default, stretched and narrow-counter instances
module tb_hazard_flush_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       mr = 1'b0, urt = 1'b0, bt = 1'b0, jmp = 1'b0;
    logic [4:0] ert = '0, irs = '0, irt = '0;
    logic       pc0, ifid0, iff0, idf0, pc1, ifid1, iff1, idf1, pc2, ifid2, iff2, idf2;
    logic [15:0] sc0, fc0, sc1, fc1;
    logic [1:0]  sc2, fc2;
    int n_run = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    hazard_flush_ctrl u0 (
        .clk(clk), .reset(reset), .EX_MemRead(mr), .EX_rt(ert), .ID_rs(irs), .ID_rt(irt),
        .ID_UsesRt(urt), .EX_BranchTaken(bt), .ID_Jump(jmp), .PCWrite(pc0), .IFID_Write(ifid0),
        .IF_Flush(iff0), .ID_Flush(idf0), .stall_cnt(sc0), .flush_cnt(fc0)
    );

    hazard_flush_ctrl #(.STALL_CYCLES(3), .FLUSH_CYCLES(2)) u1 (
        .clk(clk), .reset(reset), .EX_MemRead(mr), .EX_rt(ert), .ID_rs(irs), .ID_rt(irt),
        .ID_UsesRt(urt), .EX_BranchTaken(bt), .ID_Jump(jmp), .PCWrite(pc1), .IFID_Write(ifid1),
        .IF_Flush(iff1), .ID_Flush(idf1), .stall_cnt(sc1), .flush_cnt(fc1)
    );

    hazard_flush_ctrl #(.CNT_W(2)) u2 (
        .clk(clk), .reset(reset), .EX_MemRead(mr), .EX_rt(ert), .ID_rs(irs), .ID_rt(irt),
        .ID_UsesRt(urt), .EX_BranchTaken(bt), .ID_Jump(jmp), .PCWrite(pc2), .IFID_Write(ifid2),
        .IF_Flush(iff2), .ID_Flush(idf2), .stall_cnt(sc2), .flush_cnt(fc2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        mr = 0; urt = 0; bt = 0; jmp = 0; ert = 0; irs = 0; irt = 0;
    endtask

    task automatic load_use();
        mr = 1; ert = 5'd8; irs = 5'd8;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        tick();
        tick();
        reset = 0;
        #1;
    endtask

    initial begin
        #1;
        check("rst_pc", {31'd0, pc0}, 0);
        check("rst_ifid", {31'd0, ifid0}, 0);
        check("rst_iff", {31'd0, iff0}, 1);
        check("rst_idf", {31'd0, idf0}, 1);
        tick();
        tick();
        check("rst_sc", {16'd0, sc0}, 0);
        check("rst_fc", {16'd0, fc0}, 0);
        reset = 0;
        #1;
        check("run_pc", {31'd0, pc0}, 1);
        check("run_iff", {31'd0, iff0}, 0);
        check("run_idf", {31'd0, idf0}, 0);

        load_use();
        #1;
        check("lu_pc", {31'd0, pc0}, 0);
        check("lu_ifid", {31'd0, ifid0}, 0);
        check("lu_idf", {31'd0, idf0}, 1);
        check("lu_iff", {31'd0, iff0}, 0);
        tick();
        idle();
        #1;
        check("lu_one_cycle_pc", {31'd0, pc0}, 1);
        check("lu_sc", {16'd0, sc0}, 1);
        check("st3_c2_pc", {31'd0, pc1}, 0);
        check("st3_c2_ifid", {31'd0, ifid1}, 0);
        tick();
        check("st3_c3_pc", {31'd0, pc1}, 0);
        tick();
        check("st3_done_pc", {31'd0, pc1}, 1);
        check("st3_sc", {16'd0, sc1}, 3);

        mr = 1; ert = 5'd9; irt = 5'd9; irs = 5'd0; urt = 0;
        #1;
        check("rt_unused_pc", {31'd0, pc0}, 1);
        urt = 1;
        #1;
        check("rt_used_pc", {31'd0, pc0}, 0);
        ert = 5'd0; irs = 5'd0; irt = 5'd0;
        #1;
        check("r0_pc", {31'd0, pc0}, 1);
        check("r0_idf", {31'd0, idf0}, 0);

        do_reset();
        load_use();
        bt = 1;
        #1;
        check("br_lu_iff", {31'd0, iff1}, 1);
        check("br_lu_idf", {31'd0, idf1}, 1);
        check("br_lu_pc", {31'd0, pc1}, 1);
        tick();
        idle();
        load_use();
        #1;
        check("fl2_iff", {31'd0, iff1}, 1);
        check("fl2_idf", {31'd0, idf1}, 1);
        check("fl2_pc_ignores_lu", {31'd0, pc1}, 1);
        check("fl1_after_iff", {31'd0, iff0}, 0);
        check("fl1_fc", {16'd0, fc0}, 1);
        idle();
        tick();
        check("fl2_end_iff", {31'd0, iff1}, 0);
        check("fl2_fc", {16'd0, fc1}, 2);
        check("fl2_sc", {16'd0, sc1}, 0);

        jmp = 1;
        #1;
        check("j_iff", {31'd0, iff0}, 1);
        check("j_idf", {31'd0, idf0}, 0);
        check("j_pc", {31'd0, pc0}, 1);
        tick();
        idle();
        #1;
        check("j_fc", {16'd0, fc0}, 1);

        load_use();
        tick();
        idle();
        bt = 1;
        #1;
        check("abort_pc", {31'd0, pc1}, 1);
        check("abort_iff", {31'd0, iff1}, 1);
        tick();
        idle();
        #1;
        check("abort_flush_idf", {31'd0, idf1}, 1);
        tick();
        check("abort_run_iff", {31'd0, iff1}, 0);
        check("abort_run_pc", {31'd0, pc1}, 1);

        load_use();
        tick();
        idle();
        reset = 1;
        #1;
        check("midrst_pc", {31'd0, pc1}, 0);
        check("midrst_iff", {31'd0, iff1}, 1);
        tick();
        reset = 0;
        #1;
        check("postrst_pc", {31'd0, pc1}, 1);
        check("postrst_sc", {16'd0, sc1}, 0);
        check("postrst_fc", {16'd0, fc1}, 0);

        load_use();
        tick();
        tick();
        check("sat_sc_2", {30'd0, sc2}, 2);
        tick();
        tick();
        tick();
        check("sat_sc_5", {30'd0, sc2}, 3);
        check("wide_sc_5", {16'd0, sc0}, 5);
        idle();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
